// File: rtl/fir_pipelined_mac.sv
// fir_pipelined_mac: parametrised, fully pipelined direct-form FIR filter.
// y[n] = sum_k c[k]*x[n-k] over the last NTAPS accepted samples.
// The pipeline is one registered product stage, then a registered binary adder tree, then an output register.
// The total latency is LAT = 2 + $clog2(NTAPS).
// Coefficients are written to a shadow bank and copied to the active bank by coef_commit.
// Optional build macro FIR_ROUND_SAT_EN enables round-half-up and saturation at the output.
// Without this macro the output is truncated with wrap, and sat is tied to 0.
module fir_pipelined_mac #(
   parameter int NTAPS     = 8,
   parameter int DATA_W    = 18,
   parameter int COEF_W    = 18,
   parameter int OUT_W     = 24,
   parameter int OUT_SHIFT = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic signed [DATA_W-1:0]  din,
   input  logic                      coef_we,
   input  logic [$clog2(NTAPS)-1:0]  coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   input  logic                      coef_commit,
   output logic                      out_valid,
   output logic signed [OUT_W-1:0]   dout,
   output logic                      sat
);

   localparam int LVL    = $clog2(NTAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + LVL;
   localparam int NP     = 1 << LVL;
   localparam int NODES  = 2 * NP - 1;

   // dly[k] holds x[k]; the oldest tap is taken from dly[NTAPS-2] via x_new
   logic signed [DATA_W-1:0] dly    [0:NTAPS-2];
   logic signed [DATA_W-1:0] x_new  [0:NTAPS-1];
   logic signed [COEF_W-1:0] shadow [0:NTAPS-1];
   logic signed [COEF_W-1:0] active [0:NTAPS-1];
   logic signed [PROD_W-1:0] prod   [0:NTAPS-1];
   // Heap-ordered adder tree: leaves at NP-1.., root at 0; each depth is one register stage
   logic signed [ACC_W-1:0]  node   [0:NODES-1];
   logic [LVL:0]             vld;
   logic signed [OUT_W-1:0]  dout_nxt;
   logic                     sat_nxt;

   // Window including the sample arriving this cycle, and the per-tap products against the active bank
   always_comb begin
      x_new[0] = din;
      for (int unsigned k = 1; k < NTAPS; k++) begin
         x_new[k] = dly[k-1];
      end
      for (int unsigned k = 0; k < NTAPS; k++) begin
         prod[k] = active[k] * x_new[k];
      end
   end

   // Delay line shifts only on accepted samples
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NTAPS - 1; k++) begin
            dly[k] <= '0;
         end
      end else if (in_valid) begin
         for (int unsigned k = 0; k < NTAPS - 1; k++) begin
            dly[k] <= x_new[k];
         end
      end
   end

   // Double-buffered coefficient banks; commit copies the pre-write shadow contents
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
         shadow[0] <= COEF_W'(1);
         active[0] <= COEF_W'(1);
      end else begin
         if (coef_commit) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
               active[k] <= shadow[k];
            end
         end
         if (coef_we && (32'(coef_addr) < NTAPS)) begin
            shadow[coef_addr] <= coef_data;
         end
      end
   end

   // Product stage, adder tree and the valid bit that travels alongside them
   always_ff @(posedge clk) begin
      if (in_valid) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            node[NP-1+k] <= {{LVL{prod[k][PROD_W-1]}}, prod[k]};
         end
      end
      for (int unsigned k = NTAPS; k < NP; k++) begin
         node[NP-1+k] <= '0;
      end
      for (int unsigned i = 0; i < NP - 1; i++) begin
         node[i] <= node[2*i+1] + node[2*i+2];
      end
      if (rst) begin
         vld <= '0;
      end else begin
         vld <= {vld[LVL-1:0], in_valid};
      end
   end

`ifdef FIR_ROUND_SAT_EN
   localparam logic signed [ACC_W:0] RND =
      (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_W:0] MAXV =
      $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [ACC_W:0] MINV =
      $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
   logic signed [ACC_W:0] acc_r;

   // Round half up, then clip to the signed output range
   always_comb begin
      acc_r    = ($signed({node[0][ACC_W-1], node[0]}) + RND) >>> OUT_SHIFT;
      dout_nxt = acc_r[OUT_W-1:0];
      sat_nxt  = 1'b0;
      if (acc_r > MAXV) begin
         dout_nxt = {1'b0, {(OUT_W-1){1'b1}}};
         sat_nxt  = 1'b1;
      end else if (acc_r < MINV) begin
         dout_nxt = {1'b1, {(OUT_W-1){1'b0}}};
         sat_nxt  = 1'b1;
      end
   end
`else
   // Plain truncation with two's-complement wrap
   always_comb begin
      dout_nxt = node[0][OUT_SHIFT +: OUT_W];
      sat_nxt  = 1'b0;
   end
`endif

   // Output register; dout and sat hold between valid results
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         sat       <= 1'b0;
      end else begin
         out_valid <= vld[LVL];
         if (vld[LVL]) begin
            dout <= dout_nxt;
            sat  <= sat_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fir_pipelined_mac.sv
// Directed, table-driven bench for fir_pipelined_mac (NTAPS=8, 18-bit data/coef, OUT_SHIFT=0).
// A second instance with OUT_W=16 covers the saturation/wrap corner; expectations follow FIR_ROUND_SAT_EN.
module tb_fir_pipelined_mac;

   localparam int LAT = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [17:0] din;
   logic               coef_we;
   logic [2:0]         coef_addr;
   logic signed [17:0] coef_data;
   logic               coef_commit;
   logic               ov, sat, ov16, sat16;
   logic signed [23:0] dout;
   logic signed [15:0] dout16;

   int checks = 0;
   int errors = 0;

   fir_pipelined_mac #(.NTAPS(8), .DATA_W(18), .COEF_W(18), .OUT_W(24), .OUT_SHIFT(0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
      .out_valid(ov), .dout(dout), .sat(sat)
   );

   fir_pipelined_mac #(.NTAPS(8), .DATA_W(18), .COEF_W(18), .OUT_W(16), .OUT_SHIFT(0)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
      .out_valid(ov16), .dout(dout16), .sat(sat16)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic iv;
      int   din;
      logic we;
      int   addr;
      int   cdata;
      logic commit;
      int   exp;
   } vec_t;

   vec_t vecs[$];
   int   step_exp [10] = '{1, 3, 6, 10, 15, 21, 28, 36, 36, 36};

   function automatic vec_t mkv(logic iv, int d, logic we, int a, int cd, logic cm, int e);
      vec_t v;
      v.iv = iv; v.din = d; v.we = we; v.addr = a; v.cdata = cd; v.commit = cm; v.exp = e;
      return v;
   endfunction

   task automatic smp(input int d, input int e);
      vecs.push_back(mkv(1'b1, d, 1'b0, 0, 0, 1'b0, e));
   endtask

   task automatic cw(input int a, input int cd);
      vecs.push_back(mkv(1'b0, 0, 1'b1, a, cd, 1'b0, 0));
   endtask

   task automatic drive(input vec_t v);
      in_valid    = v.iv;
      din         = 18'(v.din);
      coef_we     = v.we;
      coef_addr   = 3'(v.addr);
      coef_data   = 18'(v.cdata);
      coef_commit = v.commit;
   endtask

   task automatic idle();
      drive(mkv(1'b0, 0, 1'b0, 0, 0, 1'b0, 0));
   endtask

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   initial begin
      int last;
      int nv;
      int j;
      int pulses;

      // ---- vector table ----
      // identity bank: output equals input, then zeros to clear the window
      smp(5, 5); smp(-7, -7); smp(100, 100);
      for (int k = 0; k < 7; k++) smp(0, 0);
      // load c[k]=k+1 and commit, then an impulse
      for (int k = 0; k < 8; k++) cw(k, k + 1);
      vecs.push_back(mkv(1'b0, 0, 1'b0, 0, 0, 1'b1, 0));
      smp(1, 1);
      for (int k = 1; k < 8; k++) smp(0, k + 1);
      // step input with in_valid gaps
      for (int k = 0; k < 10; k++) begin
         smp(1, step_exp[k]);
         vecs.push_back(mkv(1'b0, 1, 1'b0, 0, 0, 1'b0, 0));
      end
      // commit in the same cycle as a sample, together with a shadow write
      for (int k = 0; k < 8; k++) cw(k, 2);
      vecs.push_back(mkv(1'b1, 1, 1'b1, 0, 100, 1'b1, 36));
      smp(1, 16);
      vecs.push_back(mkv(1'b0, 0, 1'b0, 0, 0, 1'b1, 0));
      smp(1, 114);

      // ---- reset ----
      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_out_valid", ov, 0);
      check("reset_dout", dout, 0);
      check("reset_sat", sat, 0);
      check("reset_sat16", sat16, 0);

      // ---- table run ----
      nv   = vecs.size();
      last = 0;
      for (int i = 0; i < nv + LAT - 1; i++) begin
         if (i < nv) drive(vecs[i]); else idle();
         @(posedge clk);
         #1;
         j = i - (LAT - 1);
         if (j >= 0 && vecs[j].iv) begin
            last = vecs[j].exp;
            check($sformatf("vec%0d_valid", j), ov, 1);
         end else begin
            check($sformatf("cyc%0d_novalid", i), ov, 0);
         end
         check($sformatf("cyc%0d_dout", i), dout, last);
         check($sformatf("cyc%0d_sat", i), sat, 0);
      end

      // ---- saturation / wrap at full-scale ----
      for (int k = 0; k < 8; k++) begin
         drive(mkv(1'b0, 0, 1'b1, k, 131071, 1'b0, 0));
         @(posedge clk);
         #1;
      end
      drive(mkv(1'b0, 0, 1'b0, 0, 0, 1'b1, 0));
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 8; k++) begin
            drive(mkv(1'b1, (s == 0) ? 131071 : -131071, 1'b0, 0, 0, 1'b0, 0));
            @(posedge clk);
            #1;
         end
         idle();
         repeat (LAT - 1) @(posedge clk);
         #1;
         check($sformatf("fs%0d_valid16", s), ov16, 1);
`ifdef FIR_ROUND_SAT_EN
         check($sformatf("fs%0d_dout16", s), dout16, (s == 0) ? 32767 : -32768);
         check($sformatf("fs%0d_sat16", s), sat16, 1);
         check($sformatf("fs%0d_dout24", s), dout, (s == 0) ? 8388607 : -8388608);
         check($sformatf("fs%0d_sat24", s), sat, 1);
`else
         check($sformatf("fs%0d_dout16", s), dout16, (s == 0) ? 8 : -8);
         check($sformatf("fs%0d_sat16", s), sat16, 0);
         check($sformatf("fs%0d_dout24", s), dout, (s == 0) ? -2097144 : 2097144);
         check($sformatf("fs%0d_sat24", s), sat, 0);
`endif
      end

      // ---- reset with samples in flight ----
      for (int k = 0; k < 4; k++) begin
         drive(mkv(1'b1, 10 * (k + 1), 1'b0, 0, 0, 1'b0, 0));
         @(posedge clk);
         #1;
      end
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (ov) pulses++;
      end
      check("midrst_pulses", pulses, 0);
      check("midrst_dout", dout, 0);
      check("midrst_sat", sat, 0);
      drive(mkv(1'b1, -3, 1'b0, 0, 0, 1'b0, 0));
      @(posedge clk);
      #1;
      idle();
      repeat (LAT - 1) @(posedge clk);
      #1;
      check("postrst_valid", ov, 1);
      check("postrst_dout", dout, -3);
      check("postrst_dout16", dout16, -3);
      check("postrst_sat16", sat16, 0);
      @(posedge clk);
      #1;
      check("postrst_pulse_end", ov, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
